// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared types and constants for the sequential radix-4 Booth multiplier stage.
//   state_e        : control FSM states (IDLE / RUN / DONE)
//   booth_digit_t  : recoded Booth digit as {neg, two, one}
//   DIGIT_*        : encodings of the five legal digits 0, +1, +2, -1, -2
//   booth_iter()   : default iteration count for a given operand width
// -----------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } booth_digit_t;

    localparam booth_digit_t DIGIT_ZERO = '{neg: 1'b0, two: 1'b0, one: 1'b0};
    localparam booth_digit_t DIGIT_P1   = '{neg: 1'b0, two: 1'b0, one: 1'b1};
    localparam booth_digit_t DIGIT_P2   = '{neg: 1'b0, two: 1'b1, one: 1'b0};
    localparam booth_digit_t DIGIT_M1   = '{neg: 1'b1, two: 1'b0, one: 1'b1};
    localparam booth_digit_t DIGIT_M2   = '{neg: 1'b1, two: 1'b1, one: 1'b0};

    // One iteration per bit pair of the multiplier plus one extra for the
    // extension bits, so unsigned operands with the MSB set come out right.
    function automatic int booth_iter(input int width);
        return (width / 2) + 1;
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// -----------------------------------------------------------------------------
// booth_recoder
// Combinational radix-4 Booth recoder: one multiplier bit-triplet in, one
// signed digit out.
//   triplet_i [2:0] : {b[2i+1], b[2i], b[2i-1]}
//   digit_o         : {neg, two, one}; both 000 and 111 decode to zero
// -----------------------------------------------------------------------------
module booth_recoder
    import booth_pkg::*;
(
    input  logic [2:0]   triplet_i,
    output booth_digit_t digit_o
);

    // Standard radix-4 Booth digit table.
    always_comb begin
        digit_o = DIGIT_ZERO;
        case (triplet_i)
            3'b000:  digit_o = DIGIT_ZERO;
            3'b001:  digit_o = DIGIT_P1;
            3'b010:  digit_o = DIGIT_P1;
            3'b011:  digit_o = DIGIT_P2;
            3'b100:  digit_o = DIGIT_M2;
            3'b101:  digit_o = DIGIT_M1;
            3'b110:  digit_o = DIGIT_M1;
            3'b111:  digit_o = DIGIT_ZERO;
            default: digit_o = DIGIT_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_accum_stage.sv
// -----------------------------------------------------------------------------
// booth_accum_stage
// Sequential radix-4 Booth multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or
// unsigned, one Booth digit accumulated per clock.
//   Clk        : rising-edge clock
//   Reset_n    : asynchronous active-low reset
//   In_Valid   : operand pair valid        In_Ready  : IDLE, can accept
//   Sign       : 1 = signed operands (sampled on accept)
//   A          : multiplicand              B         : multiplier
//   Out_Valid  : Product valid             Out_Ready : consumer takes Product
//   Product    : 2*WIDTH result (mod 2^(2*WIDTH))
//   Busy       : high in RUN or DONE
// Optional build macro BOOTH_EARLY_EXIT_EN: leave RUN as soon as every
// remaining Booth digit is known to be zero.
// -----------------------------------------------------------------------------
module booth_accum_stage
    import booth_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = booth_iter(WIDTH)
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic                 Sign,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int MW    = WIDTH + 3;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_e              state_q, state_d;
    logic [PW-1:0]       amc_q, amc_d;
    logic [MW-1:0]       mp_q, mp_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]       product_q, product_d;
    logic                out_valid_q, out_valid_d;

    booth_digit_t        digit_s;
    logic [PW-1:0]       mag_s;
    logic [PW-1:0]       term_s;
    logic                accept_s;
    logic                last_iter_s;
    logic                ext_s;

    assign accept_s = In_Valid && (state_q == ST_IDLE);
    assign ext_s    = Sign & B[WIDTH-1];

    booth_recoder u_recoder (
        .triplet_i (mp_q[2:0]),
        .digit_o   (digit_s)
    );

    // Select 0/A/2A, negate for negative digits, then shift to weight 4^cnt.
    always_comb begin
        mag_s  = '0;
        term_s = '0;
        if (digit_s.two) begin
            mag_s = amc_q << 1;
        end else if (digit_s.one) begin
            mag_s = amc_q;
        end else begin
            mag_s = '0;
        end
        if (digit_s.neg) begin
            term_s = (~mag_s + {{(PW-1){1'b0}}, 1'b1}) << {cnt_q, 1'b0};
        end else begin
            term_s = mag_s << {cnt_q, 1'b0};
        end
    end

`ifdef BOOTH_EARLY_EXIT_EN
    // Remaining digits are all zero once every unconsumed multiplier bit above
    // the current triplet equals that triplet's top bit. Bits above the
    // unconsumed window are logical-shift fill and are not considered.
    always_comb begin
        logic all_same;
        all_same = 1'b1;
        for (int i = 2; i < MW; i++) begin
            if ((i <= (MW - 1 - 2 * int'(cnt_q))) && (mp_q[i] != mp_q[2])) begin
                all_same = 1'b0;
            end else begin
                all_same = all_same;
            end
        end
        last_iter_s = (cnt_q == CNT_LAST) || all_same;
    end
`else
    // Fixed-length run: stop only after the final iteration.
    always_comb begin
        last_iter_s = (cnt_q == CNT_LAST);
    end
`endif

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; DONE only releases after Product has been shown.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_iter_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_valid_q && Out_Ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        In_Ready = 1'b0;
        Busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                In_Ready = 1'b1;
                Busy     = 1'b0;
            end
            ST_RUN, ST_DONE: begin
                In_Ready = 1'b0;
                Busy     = 1'b1;
            end
            default: begin
                In_Ready = 1'b0;
                Busy     = 1'b0;
            end
        endcase
    end

    // Datapath next-state: operand latch, accumulate, result capture.
    always_comb begin
        amc_d       = amc_q;
        mp_d        = mp_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    amc_d = Sign ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
                    mp_d  = {ext_s, ext_s, B, 1'b0};
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    amc_d = amc_q;
                end
            end
            ST_RUN: begin
                acc_d = acc_q + term_s;
                mp_d  = mp_q >> 2;
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    product_d   = acc_q;
                    out_valid_d = 1'b1;
                end else if (Out_Ready) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            amc_q       <= '0;
            mp_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            amc_q       <= amc_d;
            mp_q        <= mp_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Product   = product_q;
    assign Out_Valid = out_valid_q;

endmodule

// File: tb/tb_booth_accum_stage.sv
// -----------------------------------------------------------------------------
// tb_booth_accum_stage
// Directed-vector self-checking bench for booth_accum_stage (WIDTH=32).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_booth_accum_stage;

    logic        Clk;
    logic        Reset_n;
    logic        In_Valid;
    logic        In_Ready;
    logic        Sign;
    logic [31:0] A;
    logic [31:0] B;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [63:0] Product;
    logic        Busy;

    int n_checks;
    int n_fail;

`ifdef BOOTH_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    booth_accum_stage #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Sign      (Sign),
        .A         (A),
        .B         (B),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Product   (Product),
        .Busy      (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One operation: accept, measure latency, check result, optional
    // back-pressure window with a spurious In_Valid, then hand-off.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp_p, input int exp_lat,
                          input bit hold);
        int n;
        bit seen;
        A = a; B = b; Sign = s; In_Valid = 1'b1;
        chk({tag, ".in_ready"}, {63'd0, In_Ready}, 64'd1);
        tick();
        In_Valid = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h1234_5678; Sign = ~s;
        chk({tag, ".busy"}, {63'd0, Busy}, 64'd1);
        seen = 1'b0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!seen) begin
                tick();
                n = k;
                if (Out_Valid) seen = 1'b1;
            end
        end
        chk({tag, ".done_seen"}, {63'd0, seen}, 64'd1);
        if (exp_lat > 0) chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
        chk({tag, ".product"}, Product, exp_p);
        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                In_Valid = 1'b1;
                tick();
                chk({tag, ".hold_valid"}, {63'd0, Out_Valid}, 64'd1);
                chk({tag, ".hold_product"}, Product, exp_p);
                chk({tag, ".hold_in_ready"}, {63'd0, In_Ready}, 64'd0);
            end
            In_Valid = 1'b0;
        end
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
        chk({tag, ".release_valid"}, {63'd0, Out_Valid}, 64'd0);
        chk({tag, ".release_in_ready"}, {63'd0, In_Ready}, 64'd1);
        chk({tag, ".release_busy"}, {63'd0, Busy}, 64'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        Reset_n   = 1'b0;
        In_Valid  = 1'b0;
        Out_Ready = 1'b0;
        Sign      = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset.product", Product, 64'd0);
        chk("reset.out_valid", {63'd0, Out_Valid}, 64'd0);
        chk("reset.busy", {63'd0, Busy}, 64'd0);
        Reset_n = 1'b1;
        tick();
        chk("reset.in_ready", {63'd0, In_Ready}, 64'd1);

        // Latencies: 18 fixed; early-exit values hand-counted per vector
        // (0 = not checked in that build).
        run_op("u3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, EARLY ? 3 : 18, 1'b0);
        run_op("s_m7x6", 32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, EARLY ? 0 : 18, 1'b0);
        run_op("u_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, EARLY ? 0 : 18, 1'b0);
        run_op("s_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, EARLY ? 0 : 18, 1'b0);
        run_op("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, EARLY ? 0 : 18, 1'b0);
        run_op("u_minx2", 32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000, EARLY ? 0 : 18, 1'b0);
        run_op("s_9x1", 32'd9, 32'd1, 1'b1, 64'h0000_0000_0000_0009, EARLY ? 2 : 18, 1'b0);
        run_op("bp_12x11", 32'd12, 32'd11, 1'b0, 64'h0000_0000_0000_0084, EARLY ? 0 : 18, 1'b1);

        // Out_Ready held high through a whole run must not cut it short.
        Out_Ready = 1'b1;
        A = 32'd100; B = 32'hFFFF_FFFE; Sign = 1'b1; In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        repeat (4) tick();
        chk("early_ready.busy", {63'd0, Busy}, 64'd1);
        chk("early_ready.valid", {63'd0, Out_Valid}, 64'd0);
        Out_Ready = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (!seen) begin
                    tick();
                    if (Out_Valid) seen = 1'b1;
                end
            end
            chk("early_ready.seen", {63'd0, seen}, 64'd1);
            chk("early_ready.product", Product, 64'hFFFF_FFFF_FFFF_FF38);
        end
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;

        // Reset in the middle of a fixed-length run.
        A = 32'h0001_2345; B = 32'h0000_0777; Sign = 1'b1; In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        repeat (8) tick();
        Reset_n = 1'b0;
        #1;
        chk("midreset.out_valid", {63'd0, Out_Valid}, 64'd0);
        chk("midreset.product", Product, 64'd0);
        chk("midreset.busy", {63'd0, Busy}, 64'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        chk("midreset.in_ready", {63'd0, In_Ready}, 64'd1);
        run_op("post_reset_3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, EARLY ? 3 : 18, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
